timer_cnt_core: RTL

- Counting engine of the 8-bit timer IP. Sits directly downstream of the register/APB block.
- Consumes control fields (enable, direction, clock-select, load data/strobe, interrupt enables, flag-clear strobes).
- Produces the live counter value (TCNT), the sticky overflow/underflow status flags and the interrupt outputs read back through the register block.
- Contains the clock prescaler: /1, /2, /4 or /8 count-enable generation.

---
 rtl/timer_cnt_if.sv | 39 +++
 rtl/timer_cnt_core.sv | 95 +++++++++
 2 files changed

// File: rtl/timer_cnt_if.sv
// ============================================================================
// Module      : timer_cnt_if
// Description : Control/status bundle between the timer register block and
//               the counting engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface timer_cnt_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             dir;
    logic [1:0]       cks;
    logic             load;
    logic [CNT_W-1:0] tdr;
    logic             ovf_clr;
    logic             udf_clr;
    logic             ovf_ie;
    logic             udf_ie;
    logic [CNT_W-1:0] cnt;
    logic             ovf_flag;
    logic             udf_flag;
    logic             irq_ovf;
    logic             irq_udf;
    logic             tick;

    modport master (
        output en, dir, cks, load, tdr, ovf_clr, udf_clr, ovf_ie, udf_ie,
        input  cnt, ovf_flag, udf_flag, irq_ovf, irq_udf, tick
    );

    modport slave (
        input  en, dir, cks, load, tdr, ovf_clr, udf_clr, ovf_ie, udf_ie,
        output cnt, ovf_flag, udf_flag, irq_ovf, irq_udf, tick
    );
endinterface

`default_nettype wire

// File: rtl/timer_cnt_core.sv
// ============================================================================
// Module      : timer_cnt_core
// Description : 8-bit timer counting engine with /1,/2,/4,/8 prescaler and
//               sticky overflow/underflow flags. Optional macro
//               TIMER_AUTO_RELOAD_EN reloads tdr on wrap instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_cnt_core #(
    parameter int CNT_W = 8,
    parameter int PSC_W = 3
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    timer_cnt_if.slave  bus
);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;

    logic [PSC_W-1:0] r_psc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf_flag;
    logic             r_udf_flag;
    logic             w_tick;
    logic             w_ovf_evt;
    logic             w_udf_evt;

    always_comb begin
        w_tick = 1'b0;
        case (bus.cks)
            2'b00:   w_tick = bus.en;
            2'b01:   w_tick = bus.en & r_psc[0];
            2'b10:   w_tick = bus.en & (r_psc[1:0] == 2'b11);
            default: w_tick = bus.en & (r_psc[2:0] == 3'b111);
        endcase
    end

    // A load overrides the tick, so it also suppresses the wrap events.
    assign w_ovf_evt = w_tick & ~bus.load & ~bus.dir & (r_cnt == c_CNT_MAX);
    assign w_udf_evt = w_tick & ~bus.load &  bus.dir & (r_cnt == c_CNT_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_psc <= '0;
        else if (bus.load || !bus.en)
            r_psc <= '0;
        else
            r_psc <= r_psc + PSC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (bus.load) begin
            r_cnt <= bus.tdr;
        end else if (w_ovf_evt || w_udf_evt) begin
`ifdef TIMER_AUTO_RELOAD_EN
            r_cnt <= bus.tdr;
`else
            r_cnt <= w_ovf_evt ? c_CNT_ZERO : c_CNT_MAX;
`endif
        end else if (w_tick) begin
            r_cnt <= bus.dir ? (r_cnt - CNT_W'(1)) : (r_cnt + CNT_W'(1));
        end
    end

    // Set wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_flag <= 1'b0;
            r_udf_flag <= 1'b0;
        end else begin
            if (w_ovf_evt)
                r_ovf_flag <= 1'b1;
            else if (bus.ovf_clr)
                r_ovf_flag <= 1'b0;

            if (w_udf_evt)
                r_udf_flag <= 1'b1;
            else if (bus.udf_clr)
                r_udf_flag <= 1'b0;
        end
    end

    assign bus.cnt      = r_cnt;
    assign bus.ovf_flag = r_ovf_flag;
    assign bus.udf_flag = r_udf_flag;
    assign bus.irq_ovf  = r_ovf_flag & bus.ovf_ie;
    assign bus.irq_udf  = r_udf_flag & bus.udf_ie;
    assign bus.tick     = w_tick;

endmodule

`default_nettype wire
